// File: rtl/alux_seq.sv
// alux_seq: command FIFO and issue sequencer for the complex ALU (ALUX), with a valid/ready result port.
// Optional WAIT timeout is built only when ALUX_SEQ_TIMEOUT_EN is defined.
module alux_seq #(
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 64
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [3:0]  cmd_opr,
   input  logic [63:0] cmd_a,
   input  logic [63:0] cmd_b,
   output logic        alu_start,
   output logic [3:0]  alu_opr,
   output logic [63:0] alu_inA,
   output logic [63:0] alu_inB,
   input  logic        alu_done,
   input  logic [63:0] alu_result,
   output logic        res_valid,
   input  logic        res_ready,
   output logic [63:0] res_data,
   output logic [3:0]  res_opr,
   output logic        res_err,
   output logic        busy
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   state_t        state;
   logic [3:0]    fifo_opr [DEPTH];
   logic [63:0]   fifo_a   [DEPTH];
   logic [63:0]   fifo_b   [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   logic          push;
   logic          pop;
   logic          fifo_empty;
   logic [3:0]    head_opr;
   logic          head_legal;
   logic          timeout_hit;

   function automatic logic is_legal(input logic [3:0] op);
      case (op)
         4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd6, 4'd8, 4'd9, 4'd10: is_legal = 1'b1;
         default:                                               is_legal = 1'b0;
      endcase
   endfunction

   // cmd_ready is held low during reset so no command slips in while state is being cleared
   assign cmd_ready  = !reset && (count != FULL);
   assign push       = cmd_valid && cmd_ready;
   assign fifo_empty = (count == '0);
   assign pop        = (state == IDLE) && !fifo_empty;
   assign head_opr   = fifo_opr[rd_ptr];
   assign head_legal = is_legal(head_opr);
   assign busy       = !fifo_empty || (state != IDLE);

   always_ff @(posedge clock) begin
      if (push) begin
         fifo_opr[wr_ptr] <= cmd_opr;
         fifo_a[wr_ptr]   <= cmd_a;
         fifo_b[wr_ptr]   <= cmd_b;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

`ifdef ALUX_SEQ_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT + 1);
   logic [TW-1:0] wait_cnt;

   // Counts completed WAIT cycles; expiry fires on the TIMEOUT-th one
   always_ff @(posedge clock) begin
      if (reset || state != WAIT) wait_cnt <= '0;
      else                        wait_cnt <= wait_cnt + TW'(1);
   end

   assign timeout_hit = (state == WAIT) && (wait_cnt == TW'(TIMEOUT - 1));
`else
   logic unused_timeout;
   assign unused_timeout = ^TIMEOUT;
   assign timeout_hit    = 1'b0;
`endif

   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= IDLE;
         alu_start <= 1'b0;
         alu_opr   <= '0;
         alu_inA   <= '0;
         alu_inB   <= '0;
         res_valid <= 1'b0;
         res_data  <= '0;
         res_opr   <= '0;
         res_err   <= 1'b0;
      end else begin
         alu_start <= 1'b0;
         unique case (state)
            IDLE: begin
               if (!fifo_empty) begin
                  if (head_legal) begin
                     alu_opr   <= head_opr;
                     alu_inA   <= fifo_a[rd_ptr];
                     alu_inB   <= fifo_b[rd_ptr];
                     alu_start <= 1'b1;
                     state     <= ISSUE;
                  end else begin
                     res_data  <= '0;
                     res_err   <= 1'b1;
                     res_opr   <= head_opr;
                     res_valid <= 1'b1;
                     state     <= RESP;
                  end
               end
            end
            ISSUE: state <= WAIT;
            WAIT: begin
               // A done coinciding with expiry still delivers the real result
               if (alu_done) begin
                  res_data  <= alu_result;
                  res_err   <= 1'b0;
                  res_opr   <= alu_opr;
                  res_valid <= 1'b1;
                  state     <= RESP;
               end else if (timeout_hit) begin
                  res_data  <= '0;
                  res_err   <= 1'b1;
                  res_opr   <= alu_opr;
                  res_valid <= 1'b1;
                  state     <= RESP;
               end
            end
            RESP: begin
               if (res_ready) begin
                  res_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alux_seq.sv
// tb_alux_seq: randomized scoreboard bench for alux_seq with a behavioural ALUX stand-in.
// Timeout scenarios are exercised only when ALUX_SEQ_TIMEOUT_EN is defined.
module tb_alux_seq;

   logic        clock = 1'b0;
   logic        reset;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [3:0]  cmd_opr;
   logic [63:0] cmd_a;
   logic [63:0] cmd_b;
   logic        alu_start;
   logic [3:0]  alu_opr;
   logic [63:0] alu_inA;
   logic [63:0] alu_inB;
   logic        alu_done;
   logic [63:0] alu_result;
   logic        res_valid;
   logic        res_ready;
   logic [63:0] res_data;
   logic [3:0]  res_opr;
   logic        res_err;
   logic        busy;

   alux_seq #(.DEPTH(4), .TIMEOUT(8)) dut (
      .clock(clock), .reset(reset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_opr(cmd_opr), .cmd_a(cmd_a), .cmd_b(cmd_b),
      .alu_start(alu_start), .alu_opr(alu_opr), .alu_inA(alu_inA), .alu_inB(alu_inB),
      .alu_done(alu_done), .alu_result(alu_result),
      .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_opr(res_opr),
      .res_err(res_err), .busy(busy)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [3:0]  opr;
      logic [63:0] data;
      logic        err;
   } exp_t;

   exp_t        exp_q[$];
   int          checks = 0;
   int          failures = 0;
   int          cyc = 0;
   int          starts = 0;
   int          results = 0;
   int          valid_seen = 0;
   int          last_start_edge = 0;
   int          last_valid_edge = 0;
   int          push_edge = 0;
   logic [63:0] last_res_data;
   logic [3:0]  last_res_opr;
   logic        last_res_err;
   int          ready_mode;
   int          alux_lat;
   bit          alux_hang;
   bit          alux_spurious;
   bit          alux_rand_lat;
   bit          expect_timeout;
   int          legal_ops[9] = '{0, 1, 2, 3, 4, 6, 8, 9, 10};

   always @(posedge clock) cyc <= cyc + 1;

   // Behavioural ALUX: 32-bit signed complex arithmetic; mod/ang ops use a simple stand-in
   function automatic logic [63:0] alux_fn(input logic [3:0] o, input logic [63:0] a, input logic [63:0] b);
      logic signed [31:0] ar, ai, br, bi;
      ar = a[63:32]; ai = a[31:0]; br = b[63:32]; bi = b[31:0];
      case (o)
         4'd0:    return a;
         4'd1:    return b;
         4'd2:    return {ar + br, ai + bi};
         4'd3:    return {ar - br, ai - bi};
         4'd4:    return {ar * br - ai * bi, ar * bi + ai * br};
         4'd6:    return {ar * br, ai * bi};
         4'd8:    return {63'd0, a == b};
         4'd9:    return {a[63:32] ^ a[31:0], 32'h0000_0009};
         4'd10:   return {b[63:32] ^ b[31:0], 32'h0000_000A};
         default: return 64'hBAD0_BAD0_BAD0_BAD0;
      endcase
   endfunction

   function automatic bit isLegal(input logic [3:0] o);
      foreach (legal_ops[i]) if (legal_ops[i] == int'(o)) return 1'b1;
      return 1'b0;
   endfunction

   function automatic exp_t refModel(input logic [3:0] o, input logic [63:0] a, input logic [63:0] b);
      exp_t e;
      e.opr = o;
      if (isLegal(o)) begin e.data = alux_fn(o, a, b); e.err = 1'b0; end
      else            begin e.data = 64'd0;            e.err = 1'b1; end
      return e;
   endfunction

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] required);
      checks++;
      if (actual !== required) begin
         failures++;
         $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, required);
      end
   endtask

   task automatic reportFail(input string name, input string actual, input string required);
      checks++;
      failures++;
      $display("[TB] FAIL %s: actual=%s required=%s", name, actual, required);
   endtask

   // Called just after a rising edge; returns just after the edge on which the command was accepted
   task automatic applyStimulus(input logic [3:0] o, input logic [63:0] a, input logic [63:0] b);
      exp_t e;
      int   guard = 0;
      cmd_valid = 1'b1; cmd_opr = o; cmd_a = a; cmd_b = b;
      @(negedge clock);
      while (!cmd_ready && guard < 500) begin @(negedge clock); guard++; end
      if (guard >= 500) begin
         reportFail("push_timeout", "cmd_ready stuck low", "cmd_ready high");
         cmd_valid = 1'b0;
         return;
      end
      @(posedge clock);
      e = refModel(o, a, b);
      if (expect_timeout) begin e.data = 64'd0; e.err = 1'b1; end
      exp_q.push_back(e);
      #1;
      push_edge = cyc;
      cmd_valid = 1'b0;
   endtask

   task automatic waitDrain(input int max_cycles);
      int n = 0;
      @(negedge clock);
      while ((exp_q.size() != 0 || busy) && n < max_cycles) begin @(negedge clock); n++; end
      if (n >= max_cycles) reportFail("drain_timeout", "results outstanding", "all results delivered");
      @(posedge clock);
      #1;
   endtask

   // Downstream ready generator
   initial begin
      res_ready = 1'b0;
      forever begin
         @(posedge clock);
         #1;
         case (ready_mode)
            0:       res_ready = 1'b0;
            1:       res_ready = 1'b1;
            default: res_ready = ($urandom_range(0, 3) != 0);
         endcase
      end
   end

   // ALUX stand-in: answers each start with the model result after the chosen number of WAIT cycles
   initial begin
      logic [3:0]  s_op;
      logic [63:0] s_a, s_b;
      int          n;
      alu_done = 1'b0;
      alu_result = 64'd0;
      forever begin
         @(negedge clock);
         if (alu_start && !reset) begin
            s_op = alu_opr; s_a = alu_inA; s_b = alu_inB;
            starts++;
            last_start_edge = cyc + 1;
            n = alux_rand_lat ? int'($urandom_range(1, 4)) : alux_lat;
            if (!alux_hang) begin
               if (alux_spurious) begin
                  alu_done = 1'b1;
                  alu_result = 64'hDEAD_BEEF_DEAD_BEEF;
                  @(posedge clock);
                  #1;
                  alu_done = 1'b0;
                  n = n - 1;
               end
               repeat (n) @(posedge clock);
               #1;
               alu_done = 1'b1;
               alu_result = alux_fn(s_op, s_a, s_b);
               @(posedge clock);
               #1;
               alu_done = 1'b0;
               alu_result = 64'd0;
            end
         end
      end
   end

   // Monitor: pops the scoreboard on every result handshake and checks stability while stalled
   initial begin
      exp_t        e;
      bit          held_v = 1'b0;
      bit          prev_valid = 1'b0;
      logic [63:0] held_data;
      logic [3:0]  held_opr;
      logic        held_err;
      forever begin
         @(negedge clock);
         if (reset) begin
            held_v = 1'b0;
            prev_valid = 1'b0;
         end else begin
            if (res_valid) begin
               valid_seen++;
               if (!prev_valid) last_valid_edge = cyc + 1;
            end
            if (held_v) begin
               checkOutput("stall_valid_held", 64'(res_valid), 64'd1);
               checkOutput("stall_data_stable", res_data, held_data);
               checkOutput("stall_opr_stable", 64'(res_opr), 64'(held_opr));
               checkOutput("stall_err_stable", 64'(res_err), 64'(held_err));
            end
            held_v = 1'b0;
            if (res_valid && res_ready) begin
               results++;
               last_res_data = res_data;
               last_res_opr = res_opr;
               last_res_err = res_err;
               if (exp_q.size() == 0) begin
                  reportFail("unexpected_result", $sformatf("opr=%0h data=%0h", res_opr, res_data), "no result");
               end else begin
                  e = exp_q.pop_front();
                  checkOutput("res_opr", 64'(res_opr), 64'(e.opr));
                  checkOutput("res_data", res_data, e.data);
                  checkOutput("res_err", 64'(res_err), 64'(e.err));
               end
            end else if (res_valid) begin
               held_v = 1'b1;
               held_data = res_data;
               held_opr = res_opr;
               held_err = res_err;
            end
            prev_valid = res_valid;
         end
      end
   end

   initial begin
      #500000;
      reportFail("global_watchdog", "simulation still running", "finished");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      int          t, s0, r0, v0;
      logic [63:0] rnd_a, rnd_b;
      reset = 1'b1; cmd_valid = 1'b0; cmd_opr = 4'd0; cmd_a = 64'd0; cmd_b = 64'd0;
      ready_mode = 0; alux_lat = 2; alux_hang = 1'b0; alux_spurious = 1'b0;
      alux_rand_lat = 1'b0; expect_timeout = 1'b0;

      $display("[TB] reset state");
      repeat (3) @(posedge clock);
      @(negedge clock);
      checkOutput("reset_alu_start", 64'(alu_start), 64'd0);
      checkOutput("reset_alu_opr", 64'(alu_opr), 64'd0);
      checkOutput("reset_alu_inA", alu_inA, 64'd0);
      checkOutput("reset_res_valid", 64'(res_valid), 64'd0);
      checkOutput("reset_res_data", res_data, 64'd0);
      checkOutput("reset_res_err", 64'(res_err), 64'd0);
      checkOutput("reset_busy", 64'(busy), 64'd0);
      checkOutput("reset_cmd_ready", 64'(cmd_ready), 64'd0);
      @(posedge clock);
      #1 reset = 1'b0;
      @(negedge clock);
      checkOutput("cmd_ready_after_reset", 64'(cmd_ready), 64'd1);
      @(posedge clock);
      #1;

      $display("[TB] add latency");
      ready_mode = 1; alux_lat = 2; s0 = starts;
      applyStimulus(4'd2, {32'd3, 32'd4}, {32'd1, 32'd2});
      t = push_edge;
      waitDrain(60);
      checkOutput("add_start_edge", 64'(last_start_edge), 64'(t + 2));
      checkOutput("add_valid_edge", 64'(last_valid_edge), 64'(t + 5));
      checkOutput("add_start_count", 64'(starts - s0), 64'd1);
      checkOutput("add_data", last_res_data, {32'd4, 32'd6});

      $display("[TB] done during issue is ignored");
      alux_spurious = 1'b1; alux_lat = 3;
      applyStimulus(4'd3, {$urandom, $urandom}, {$urandom, $urandom});
      t = push_edge;
      waitDrain(60);
      checkOutput("spurious_valid_edge", 64'(last_valid_edge), 64'(t + 6));
      alux_spurious = 1'b0;

      $display("[TB] illegal opcode");
      s0 = starts;
      applyStimulus(4'd5, {$urandom, $urandom}, {$urandom, $urandom});
      t = push_edge;
      waitDrain(60);
      checkOutput("illegal_valid_edge", 64'(last_valid_edge), 64'(t + 2));
      checkOutput("illegal_no_start", 64'(starts - s0), 64'd0);
      checkOutput("illegal_err", 64'(last_res_err), 64'd1);
      checkOutput("illegal_data", last_res_data, 64'd0);
      checkOutput("illegal_opr", 64'(last_res_opr), 64'd5);

      $display("[TB] full FIFO and backpressure");
      ready_mode = 0; alux_lat = 20; r0 = results;
      for (int i = 0; i < 5; i++) applyStimulus(4'(i), {$urandom, $urandom}, {$urandom, $urandom});
      alux_lat = 2;
      @(negedge clock);
      checkOutput("full_cmd_ready", 64'(cmd_ready), 64'd0);
      cmd_valid = 1'b1; cmd_opr = 4'd7; cmd_a = 64'd7; cmd_b = 64'd7;
      repeat (3) begin
         @(posedge clock);
         @(negedge clock);
         checkOutput("refused_push_ready", 64'(cmd_ready), 64'd0);
      end
      cmd_valid = 1'b0;
      @(posedge clock);
      #1;
      repeat (25) @(posedge clock);
      #1 ready_mode = 1;
      waitDrain(300);
      checkOutput("full_result_count", 64'(results - r0), 64'd5);
      checkOutput("full_last_opr", 64'(last_res_opr), 64'd4);

      $display("[TB] reset during WAIT");
      alux_lat = 15;
      for (int i = 0; i < 3; i++) applyStimulus(4'd4, {$urandom | 32'h1, $urandom}, {$urandom, $urandom});
      repeat (3) @(posedge clock);
      #1 reset = 1'b1;
      @(posedge clock);
      #1 reset = 1'b0;
      exp_q.delete();
      @(negedge clock);
      checkOutput("midreset_alu_start", 64'(alu_start), 64'd0);
      checkOutput("midreset_alu_opr", 64'(alu_opr), 64'd0);
      checkOutput("midreset_alu_inA", alu_inA, 64'd0);
      checkOutput("midreset_alu_inB", alu_inB, 64'd0);
      checkOutput("midreset_res_valid", 64'(res_valid), 64'd0);
      checkOutput("midreset_res_data", res_data, 64'd0);
      checkOutput("midreset_res_opr", 64'(res_opr), 64'd0);
      checkOutput("midreset_res_err", 64'(res_err), 64'd0);
      checkOutput("midreset_busy", 64'(busy), 64'd0);
      v0 = valid_seen; s0 = starts;
      repeat (25) @(posedge clock);
      #1;
      checkOutput("midreset_no_result", 64'(valid_seen - v0), 64'd0);
      checkOutput("midreset_no_start", 64'(starts - s0), 64'd0);

      $display("[TB] randomized traffic");
      ready_mode = 2; alux_rand_lat = 1'b1; r0 = results;
      for (int i = 0; i < 40; i++) begin
         rnd_a = {$urandom, $urandom};
         rnd_b = ($urandom_range(0, 3) == 0) ? rnd_a : {$urandom, $urandom};
         applyStimulus(4'($urandom_range(0, 15)), rnd_a, rnd_b);
         repeat ($urandom_range(0, 2)) @(posedge clock);
         #1;
      end
      waitDrain(3000);
      alux_rand_lat = 1'b0;
      checkOutput("random_result_count", 64'(results - r0), 64'd40);

`ifdef ALUX_SEQ_TIMEOUT_EN
      $display("[TB] WAIT timeout");
      ready_mode = 1; alux_hang = 1'b1; expect_timeout = 1'b1;
      applyStimulus(4'd2, {$urandom, $urandom}, {$urandom, $urandom});
      t = push_edge;
      expect_timeout = 1'b0;
      waitDrain(100);
      checkOutput("timeout_valid_edge", 64'(last_valid_edge), 64'(t + 11));
      checkOutput("timeout_err", 64'(last_res_err), 64'd1);
      checkOutput("timeout_data", last_res_data, 64'd0);
      alux_hang = 1'b0; alux_lat = 8;
      applyStimulus(4'd2, {32'd3, 32'd4}, {32'd1, 32'd2});
      t = push_edge;
      waitDrain(100);
      checkOutput("done_at_expiry_valid_edge", 64'(last_valid_edge), 64'(t + 11));
      checkOutput("done_at_expiry_err", 64'(last_res_err), 64'd0);
      checkOutput("done_at_expiry_data", last_res_data, {32'd4, 32'd6});
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
